// File: rtl/sound_pkg.sv
// Shared constants and types for the sound controller.
// Register map, reset values and the write bundle.
package sound_pkg;

  localparam int NUM_CH = 4;

  localparam logic [2:0] REG_PER_HI = 3'd0;
  localparam logic [2:0] REG_PER_LO = 3'd1;
  localparam logic [2:0] REG_VOL    = 3'd2;
  localparam logic [2:0] REG_WIDTH  = 3'd3;
  localparam logic [2:0] REG_RATE   = 3'd4;

  localparam logic [15:0] PERIOD_RST = 16'h377D;
  localparam logic [4:0]  VOLUME_RST = 5'd0;
  localparam logic [2:0]  WIDTH_RST  = 3'd3;

  typedef struct packed {
    logic [1:0] ch;
    logic [2:0] idx;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/sound_env.sv
// Per-channel volume envelope.
// Holds decay rate, tick counter and current volume.
module sound_env
  import sound_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       vol_we,
  input  logic [4:0] vol_data,
  input  logic       rate_we,
  input  logic [3:0] rate_data,
  output logic [4:0] volume
);

  logic [3:0] rate;
  logic [3:0] cnt;
  logic       run;
  logic       step;

  assign run  = tick && (rate != 4'd0);
  assign step = run && ((cnt + 4'd1) == rate);

  // Any register write pre-empts the envelope for this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate   <= 4'd0;
      cnt    <= 4'd0;
      volume <= VOLUME_RST;
    end else begin
      if (rate_we)
        rate <= rate_data;

      if (vol_we || rate_we)
        cnt <= 4'd0;
      else if (run)
        cnt <= step ? 4'd0 : cnt + 4'd1;

      if (vol_we)
        volume <= vol_data;
      else if (step && !rate_we && volume != 5'd0)
        volume <= volume - 5'd1;
    end
  end

endmodule

// File: rtl/sound_ctrl.sv
// Sound channel register block with two round-robin
// write requesters (CPU and front panel).
module sound_ctrl
  import sound_pkg::*;
#(
  parameter int NUM_CH = sound_pkg::NUM_CH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_valid,
  output logic                 cpu_ready,
  input  logic [4:0]           cpu_addr,
  input  logic [7:0]           cpu_data,
  input  logic                 pnl_valid,
  output logic                 pnl_ready,
  input  logic [4:0]           pnl_addr,
  input  logic [7:0]           pnl_data,
  input  logic                 tick,
  output logic [NUM_CH*16-1:0] period,
  output logic [NUM_CH*5-1:0]  volume,
  output logic [NUM_CH*3-1:0]  width
);

  logic    last_pnl;
  logic    grant_cpu;
  logic    grant_pnl;
  logic    wr_en;
  wr_req_t wr;

  // Contention goes to whoever was not served last.
  assign grant_cpu = rst_n && cpu_valid &&
                     (!pnl_valid || last_pnl);
  assign grant_pnl = rst_n && pnl_valid &&
                     (!cpu_valid || !last_pnl);

  assign cpu_ready = grant_cpu;
  assign pnl_ready = grant_pnl;
  assign wr_en     = grant_cpu || grant_pnl;

  assign wr = grant_pnl ? wr_req_t'({pnl_addr, pnl_data})
                        : wr_req_t'({cpu_addr, cpu_data});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_pnl <= 1'b1;
    else if (wr_en)
      last_pnl <= grant_pnl;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    localparam logic [1:0] CH = 2'(g);

    logic        hit;
    logic [15:0] per_q;
    logic [2:0]  wid_q;

    assign hit = wr_en && (wr.ch == CH);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        per_q <= PERIOD_RST;
        wid_q <= WIDTH_RST;
      end else if (hit) begin
        if (wr.idx == REG_PER_HI)
          per_q[15:8] <= wr.data;
        if (wr.idx == REG_PER_LO)
          per_q[7:0] <= wr.data;
        if (wr.idx == REG_WIDTH)
          wid_q <= wr.data[2:0];
      end
    end

    sound_env u_env (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .vol_we    (hit && (wr.idx == REG_VOL)),
      .vol_data  (wr.data[4:0]),
      .rate_we   (hit && (wr.idx == REG_RATE)),
      .rate_data (wr.data[3:0]),
      .volume    (volume[5*g +: 5])
    );

    assign period[16*g +: 16] = per_q;
    assign width[3*g +: 3]    = wid_q;
  end

endmodule

// File: tb/tb_sound_ctrl.sv
// Scoreboard bench for sound_ctrl: stimulus queues expected
// register snapshots, a negedge monitor checks each event.
module tb_sound_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid, pnl_valid, tick;
  logic        cpu_ready, pnl_ready;
  logic [4:0]  cpu_addr, pnl_addr;
  logic [7:0]  cpu_data, pnl_data;
  logic [63:0] period;
  logic [19:0] volume;
  logic [11:0] width;

  always #5 clk = ~clk;

  sound_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .pnl_valid (pnl_valid),
    .pnl_ready (pnl_ready),
    .pnl_addr  (pnl_addr),
    .pnl_data  (pnl_data),
    .tick      (tick),
    .period    (period),
    .volume    (volume),
    .width     (width)
  );

  localparam logic [2:0] K_CPU = 3'b001;
  localparam logic [2:0] K_PNL = 3'b010;
  localparam logic [2:0] K_TCK = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [63:0] per;
    logic [19:0] vol;
    logic [11:0] wid;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [15:0] e_per[4];
  logic [4:0]  e_vol[4];
  logic [2:0]  e_wid[4];
  int          errors = 0;
  int          checks = 0;
  logic        pend = 1'b0;
  logic [2:0]  pkind;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic exp_reset();
    for (int i = 0; i < 4; i++) begin
      e_per[i] = 16'h377D;
      e_vol[i] = 5'd0;
      e_wid[i] = 3'd3;
    end
  endtask

  task automatic push(input logic [2:0] kind);
    exp_t x;
    x.kind = kind;
    for (int i = 0; i < 4; i++) begin
      x.per[16*i +: 16] = e_per[i];
      x.vol[5*i +: 5]   = e_vol[i];
      x.wid[3*i +: 3]   = e_wid[i];
    end
    q.push_back(x);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_period"}, period, {4{16'h377D}});
    chk({tag, "_volume"}, volume, 20'd0);
    chk({tag, "_width"}, width, {4{3'd3}});
  endtask

  // Monitor: record events at one negedge, check the next.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %b want none",
                   pkind);
        end else begin
          e = q.pop_front();
          chk("kind", pkind, e.kind);
          chk("period", period, e.per);
          chk("volume", volume, e.vol);
          chk("width", width, e.wid);
        end
      end
      pkind = {tick, pnl_valid && pnl_ready,
               cpu_valid && cpu_ready};
      pend = (pkind != 3'b000);
    end
  end

  task automatic wr(input bit pnl, input logic [4:0] a,
                    input logic [7:0] d, input bit tk);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (pnl) begin
      pnl_valid = 1'b1; pnl_addr = a; pnl_data = d;
    end else begin
      cpu_valid = 1'b1; cpu_addr = a; cpu_data = d;
    end
    tick = tk;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = pnl ? pnl_ready : cpu_ready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: got no ready want ready a=%b", a);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    pnl_valid = 1'b0;
    tick = 1'b0;
  endtask

  task automatic tk();
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cv[4];
    logic [7:0] pv[4];
    int ci, pi, n;
    cv[0] = 8'd5; cv[1] = 8'd6; cv[2] = 8'd7; cv[3] = 8'd8;
    pv[0] = 8'd9; pv[1] = 8'd10; pv[2] = 8'd11; pv[3] = 8'd12;

    // Reset with both requesters asserting valid.
    rst_n = 1'b0;
    tick = 1'b0;
    cpu_valid = 1'b1; cpu_addr = 5'b00_010; cpu_data = 8'hFF;
    pnl_valid = 1'b1; pnl_addr = 5'b00_011; pnl_data = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_pnl_ready", pnl_ready, 1'b0);
    chk_reset_outs("rst");
    cpu_valid = 1'b0;
    pnl_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_rst");
    exp_reset();

    // Contention on ch0 volume: CPU first, then alternation.
    for (int k = 0; k < 8; k++) begin
      e_vol[0] = (k % 2 == 0) ? cv[k/2][4:0] : pv[k/2][4:0];
      push((k % 2 == 0) ? K_CPU : K_PNL);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_addr = 5'b00_010; cpu_data = cv[0];
    pnl_valid = 1'b1; pnl_addr = 5'b00_010; pnl_data = pv[0];
    ci = 0; pi = 0; n = 0;
    while ((ci < 4 || pi < 4) && n < 20) begin
      bit gc, gp;
      @(negedge clk);
      gc = cpu_ready;
      gp = pnl_ready;
      @(posedge clk); #1;
      n++;
      if (gc) begin
        ci++;
        if (ci < 4) cpu_data = cv[ci];
        else cpu_valid = 1'b0;
      end
      if (gp) begin
        pi++;
        if (pi < 4) pnl_data = pv[pi];
        else pnl_valid = 1'b0;
      end
    end
    cpu_valid = 1'b0;
    pnl_valid = 1'b0;
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL arb_timeout: got %0d/%0d grants want 4/4",
               ci, pi);
    end

    // Period byte writes on ch1.
    e_per[1] = 16'h127D; push(K_CPU);
    wr(0, 5'b01_000, 8'h12, 0);
    e_per[1] = 16'h1234; push(K_CPU);
    wr(0, 5'b01_001, 8'h34, 0);

    // Unused data bits, reserved index, low byte only.
    e_wid[3] = 3'd5; push(K_PNL);
    wr(1, 5'b11_011, 8'hFD, 0);
    e_vol[1] = 5'd6; push(K_CPU);
    wr(0, 5'b01_010, 8'hE6, 0);
    push(K_CPU);
    wr(0, 5'b01_101, 8'hFF, 0);
    e_per[0] = 16'h37AB; push(K_PNL);
    wr(1, 5'b00_001, 8'hAB, 0);

    // ch2 volume 3, decay 2, eight ticks.
    e_vol[2] = 5'd3; push(K_CPU);
    wr(0, 5'b10_010, 8'hE3, 0);
    push(K_CPU);
    wr(0, 5'b10_100, 8'hF2, 0);
    for (int t = 1; t <= 8; t++) begin
      if (t == 2) e_vol[2] = 5'd2;
      if (t == 4) e_vol[2] = 5'd1;
      if (t == 6) e_vol[2] = 5'd0;
      push(K_TCK);
      tk();
    end

    // Volume write colliding with a decrementing tick.
    push(K_CPU);
    wr(0, 5'b10_100, 8'h02, 0);
    push(K_TCK);
    tk();
    e_vol[3] = 5'd4; push(K_CPU);
    wr(0, 5'b11_010, 8'h04, 0);
    push(K_CPU);
    wr(0, 5'b11_100, 8'h01, 0);
    e_vol[2] = 5'd7; e_vol[3] = 5'd3;
    push(K_CPU | K_TCK);
    wr(0, 5'b10_010, 8'h07, 1);
    e_vol[3] = 5'd2; push(K_TCK);
    tk();
    e_vol[2] = 5'd6; e_vol[3] = 5'd1; push(K_TCK);
    tk();

    // Reset while a panel request is outstanding.
    @(posedge clk); #1;
    pnl_valid = 1'b1; pnl_addr = 5'b00_010; pnl_data = 8'h1F;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_pnl_ready", pnl_ready, 1'b0);
    @(negedge clk);
    chk_reset_outs("midrst");
    @(posedge clk); #1;
    pnl_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("after_midrst");
    exp_reset();
    e_vol[0] = 5'h11; push(K_PNL);
    wr(1, 5'b00_010, 8'h11, 0);

    repeat (3) @(negedge clk);
    chk("queue_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
